// File: rtl/sram_responder.sv
// On-chip SRAM responder serving active-low CE/OE/WE/UB/LB strobes with configurable read latency.
// Optional sticky OE/WE conflict detector enabled by defining SRAM_CONFLICT_CHK_EN.
//
// state   | meaning
// IDLE    | no strobe being serviced, outputs cleared
// RD_WAIT | read accepted, latency down-counter running
// RD_HOLD | read data presented, Data_valid held while ADDR is stable
// WR_HOLD | write committed, waiting for WE release (one commit per strobe)
module sram_responder #(
    parameter int ADDR_W       = 10,
    parameter int READ_LATENCY = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Mem_CE,
    input  logic        Mem_OE,
    input  logic        Mem_WE,
    input  logic        Mem_UB,
    input  logic        Mem_LB,
    input  logic [19:0] ADDR,
    input  logic [15:0] Data_in,
    output logic [15:0] Data_out,
    output logic        Data_valid,
    output logic        Conflict
);

    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RD_WAIT = 2'd1;
    localparam logic [1:0] RD_HOLD = 2'd2;
    localparam logic [1:0] WR_HOLD = 2'd3;

    localparam logic [2:0] LAT_FIRST   = 3'(READ_LATENCY - 1);
    localparam logic [2:0] LAT_RESTART = 3'(READ_LATENCY);

    logic [1:0]        state;
    logic [2:0]        cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] req_addr;
    logic [15:0]       mem [DEPTH];
    logic [15:0]       lane_mask;
    logic [15:0]       rd_word;
    logic              rd_strobe;
    logic              wr_strobe;
    logic              wr_commit;
    logic              unused_addr_hi;

    assign req_addr       = ADDR[ADDR_W-1:0];
    assign unused_addr_hi = ^ADDR[19:ADDR_W];

    assign rd_strobe = !Mem_CE && !Mem_OE && Mem_WE;
    assign wr_strobe = !Mem_CE && !Mem_WE;
    assign lane_mask = {{8{!Mem_UB}}, {8{!Mem_LB}}};
    assign rd_word   = mem[req_addr] & lane_mask;

    // Only the first edge of a write strobe commits; WR_HOLD blocks repeats.
    assign wr_commit = !Reset && wr_strobe && (state != WR_HOLD);

    always_ff @(posedge Clk) begin
        if (wr_commit) begin
            if (!Mem_UB) mem[req_addr][15:8] <= Data_in[15:8];
            if (!Mem_LB) mem[req_addr][7:0]  <= Data_in[7:0];
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= IDLE;
            cnt        <= '0;
            addr_q     <= '0;
            Data_out   <= '0;
            Data_valid <= 1'b0;
        end else if (!rd_strobe && !wr_strobe) begin
            state      <= IDLE;
            cnt        <= '0;
            Data_out   <= '0;
            Data_valid <= 1'b0;
        end else if (wr_strobe) begin
            state      <= WR_HOLD;
            Data_out   <= '0;
            Data_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    addr_q <= req_addr;
                    if (READ_LATENCY == 1) begin
                        state      <= RD_HOLD;
                        Data_out   <= rd_word;
                        Data_valid <= 1'b1;
                    end else begin
                        state <= RD_WAIT;
                        cnt   <= LAT_FIRST;
                    end
                end
                RD_WAIT: begin
                    if (req_addr != addr_q) begin
                        addr_q <= req_addr;
                        cnt    <= LAT_RESTART;
                    end else if (cnt <= 3'd1) begin
                        state      <= RD_HOLD;
                        cnt        <= '0;
                        Data_out   <= rd_word;
                        Data_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                RD_HOLD: begin
                    // A new address mid-hold restarts the full latency from RD_WAIT.
                    if (req_addr != addr_q) begin
                        state      <= RD_WAIT;
                        addr_q     <= req_addr;
                        cnt        <= LAT_RESTART;
                        Data_out   <= '0;
                        Data_valid <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    Data_out   <= '0;
                    Data_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef SRAM_CONFLICT_CHK_EN
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Conflict <= 1'b0;
        end else if (!Mem_CE && !Mem_OE && !Mem_WE) begin
            Conflict <= 1'b1;
        end
    end
`else
    assign Conflict = 1'b0;
`endif

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder: one instance at latency 1, one at latency 3, sharing the strobe bus.
module tb_sram_responder;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Mem_CE, Mem_OE, Mem_WE, Mem_UB, Mem_LB;
    logic [19:0] ADDR;
    logic [15:0] Data_in;
    logic [15:0] dout1, dout3;
    logic        valid1, valid3;
    logic        conf1, conf3;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    sram_responder #(.ADDR_W(10), .READ_LATENCY(1)) dut (
        .Clk(Clk), .Reset(Reset), .Mem_CE(Mem_CE), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE),
        .Mem_UB(Mem_UB), .Mem_LB(Mem_LB), .ADDR(ADDR), .Data_in(Data_in),
        .Data_out(dout1), .Data_valid(valid1), .Conflict(conf1)
    );

    sram_responder #(.ADDR_W(10), .READ_LATENCY(3)) dut3 (
        .Clk(Clk), .Reset(Reset), .Mem_CE(Mem_CE), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE),
        .Mem_UB(Mem_UB), .Mem_LB(Mem_LB), .ADDR(ADDR), .Data_in(Data_in),
        .Data_out(dout3), .Data_valid(valid3), .Conflict(conf3)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic release_bus();
        Mem_CE = 1'b1; Mem_OE = 1'b1; Mem_WE = 1'b1; Mem_UB = 1'b1; Mem_LB = 1'b1;
    endtask

    task automatic write_word(input logic [19:0] a, input logic [15:0] d,
                              input logic ub, input logic lb);
        Mem_CE = 1'b0; Mem_OE = 1'b1; Mem_WE = 1'b0; Mem_UB = ub; Mem_LB = lb;
        ADDR = a; Data_in = d;
        tick();
        release_bus();
        tick();
    endtask

    task automatic start_read(input logic [19:0] a, input logic ub, input logic lb);
        Mem_CE = 1'b0; Mem_OE = 1'b0; Mem_WE = 1'b1; Mem_UB = ub; Mem_LB = lb;
        ADDR = a;
    endtask

    // One-edge read on the latency-1 instance, then release.
    task automatic read1(input logic [19:0] a, input logic ub, input logic lb,
                         output logic [15:0] d, output logic v);
        start_read(a, ub, lb);
        tick();
        d = dout1;
        v = valid1;
        release_bus();
        tick();
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        release_bus();
        ADDR = '0; Data_in = '0;
        tick();
        tick();
        checks++;
        if (dout1 !== 16'h0000 || valid1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_lat1: data=%h valid=%b, want 0000 0", dout1, valid1);
        end
        checks++;
        if (dout3 !== 16'h0000 || valid3 !== 1'b0) begin
            errors++;
            $display("FAIL reset_lat3: data=%h valid=%b, want 0000 0", dout3, valid3);
        end
        checks++;
        if (conf1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_conflict: got %b want 0", conf1);
        end
        Reset = 1'b0;
        tick();
    endtask

    task automatic test_write_read();
        write_word(20'd5, 16'hBEEF, 1'b0, 1'b0);
        start_read(20'd5, 1'b0, 1'b0);
        tick();
        checks++;
        if (valid1 !== 1'b1 || dout1 !== 16'hBEEF) begin
            errors++;
            $display("FAIL rd_beef: valid=%b data=%h, want 1 beef", valid1, dout1);
        end
        checks++;
        if (valid3 !== 1'b0) begin
            errors++;
            $display("FAIL rd_beef_lat3_early: valid=%b want 0", valid3);
        end
        tick();
        checks++;
        if (valid1 !== 1'b1 || dout1 !== 16'hBEEF) begin
            errors++;
            $display("FAIL rd_beef_hold: valid=%b data=%h, want 1 beef", valid1, dout1);
        end
        release_bus();
        tick();
        checks++;
        if (valid1 !== 1'b0 || dout1 !== 16'h0000) begin
            errors++;
            $display("FAIL rd_release: valid=%b data=%h, want 0 0000", valid1, dout1);
        end
    endtask

    task automatic test_byte_lanes();
        logic [15:0] d;
        logic        v;
        write_word(20'd7, 16'hFFFF, 1'b0, 1'b0);
        write_word(20'd7, 16'h1234, 1'b1, 1'b0);
        read1(20'd7, 1'b0, 1'b0, d, v);
        checks++;
        if (d !== 16'hFF34 || v !== 1'b1) begin
            errors++;
            $display("FAIL lb_write: data=%h valid=%b, want ff34 1", d, v);
        end
        write_word(20'd7, 16'h5678, 1'b0, 1'b1);
        read1(20'd7, 1'b0, 1'b0, d, v);
        checks++;
        if (d !== 16'h5634) begin
            errors++;
            $display("FAIL ub_write: data=%h want 5634", d);
        end
        write_word(20'd7, 16'hAAAA, 1'b1, 1'b1);
        read1(20'd7, 1'b0, 1'b0, d, v);
        checks++;
        if (d !== 16'h5634) begin
            errors++;
            $display("FAIL no_lane_write: data=%h want 5634", d);
        end
        read1(20'd5, 1'b1, 1'b0, d, v);
        checks++;
        if (d !== 16'h00EF || v !== 1'b1) begin
            errors++;
            $display("FAIL lb_read: data=%h valid=%b, want 00ef 1", d, v);
        end
        read1(20'd5, 1'b1, 1'b1, d, v);
        checks++;
        if (d !== 16'h0000 || v !== 1'b1) begin
            errors++;
            $display("FAIL no_lane_read: data=%h valid=%b, want 0000 1", d, v);
        end
        read1(20'd1029, 1'b0, 1'b0, d, v);
        checks++;
        if (d !== 16'hBEEF) begin
            errors++;
            $display("FAIL addr_alias: data=%h want beef", d);
        end
    endtask

    task automatic test_single_commit();
        logic [15:0] d;
        logic        v;
        Mem_CE = 1'b0; Mem_OE = 1'b1; Mem_WE = 1'b0; Mem_UB = 1'b0; Mem_LB = 1'b0;
        ADDR = 20'd3;
        Data_in = 16'h0001;
        tick();
        Data_in = 16'h0002;
        tick();
        Data_in = 16'h0003;
        tick();
        release_bus();
        tick();
        read1(20'd3, 1'b0, 1'b0, d, v);
        checks++;
        if (d !== 16'h0001) begin
            errors++;
            $display("FAIL single_commit: data=%h want 0001", d);
        end
    endtask

    task automatic test_write_priority();
        logic [15:0] d;
        logic        v;
        start_read(20'd5, 1'b0, 1'b0);
        tick();
        Mem_WE = 1'b0;
        ADDR = 20'd11;
        Data_in = 16'h4321;
        tick();
        checks++;
        if (valid1 !== 1'b0) begin
            errors++;
            $display("FAIL wr_prio_valid: valid=%b want 0", valid1);
        end
        release_bus();
        tick();
        read1(20'd11, 1'b0, 1'b0, d, v);
        checks++;
        if (d !== 16'h4321) begin
            errors++;
            $display("FAIL wr_prio_commit: data=%h want 4321", d);
        end
    endtask

    task automatic test_latency3();
        logic [1:0] want_v;
        write_word(20'd9,  16'hA5A5, 1'b0, 1'b0);
        write_word(20'd10, 16'h5A5A, 1'b0, 1'b0);
        start_read(20'd9, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (valid3 !== 1'b0) begin
                errors++;
                $display("FAIL lat3_wait%0d: valid=%b want 0", i, valid3);
            end
        end
        tick();
        checks++;
        if (valid3 !== 1'b1 || dout3 !== 16'hA5A5) begin
            errors++;
            $display("FAIL lat3_valid: valid=%b data=%h, want 1 a5a5", valid3, dout3);
        end
        tick();
        ADDR = 20'd10;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (valid3 !== 1'b0) begin
                errors++;
                $display("FAIL lat3_restart%0d: valid=%b want 0", i, valid3);
            end
            want_v = (i == 0) ? 2'd0 : 2'd1;
            checks++;
            if (valid1 !== want_v[0]) begin
                errors++;
                $display("FAIL lat1_restart%0d: valid=%b want %b", i, valid1, want_v[0]);
            end
        end
        tick();
        checks++;
        if (valid3 !== 1'b1 || dout3 !== 16'h5A5A) begin
            errors++;
            $display("FAIL lat3_revalid: valid=%b data=%h, want 1 5a5a", valid3, dout3);
        end
        checks++;
        if (dout1 !== 16'h5A5A) begin
            errors++;
            $display("FAIL lat1_revalid: data=%h want 5a5a", dout1);
        end
        release_bus();
        tick();
    endtask

    task automatic test_reset_mid_op();
        start_read(20'd9, 1'b0, 1'b0);
        tick();
        Reset = 1'b1;
        tick();
        checks++;
        if (valid3 !== 1'b0 || dout3 !== 16'h0000) begin
            errors++;
            $display("FAIL rst_mid_read: valid=%b data=%h, want 0 0000", valid3, dout3);
        end
        Reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (valid3 !== 1'b0) begin
                errors++;
                $display("FAIL rst_reread_wait%0d: valid=%b want 0", i, valid3);
            end
        end
        tick();
        checks++;
        if (valid3 !== 1'b1 || dout3 !== 16'hA5A5) begin
            errors++;
            $display("FAIL rst_reread: valid=%b data=%h, want 1 a5a5", valid3, dout3);
        end
        release_bus();
        tick();
        Reset = 1'b1;
        Mem_CE = 1'b0; Mem_OE = 1'b1; Mem_WE = 1'b0; Mem_UB = 1'b0; Mem_LB = 1'b0;
        ADDR = 20'd9; Data_in = 16'h0000;
        tick();
        release_bus();
        tick();
        Reset = 1'b0;
        tick();
        start_read(20'd9, 1'b0, 1'b0);
        tick();
        checks++;
        if (dout1 !== 16'hA5A5) begin
            errors++;
            $display("FAIL rst_mid_write: data=%h want a5a5", dout1);
        end
        release_bus();
        tick();
    endtask

    task automatic test_conflict();
        logic [15:0] d;
        logic        v;
        logic        want_c;
`ifdef SRAM_CONFLICT_CHK_EN
        want_c = 1'b1;
`else
        want_c = 1'b0;
`endif
        Mem_CE = 1'b0; Mem_OE = 1'b0; Mem_WE = 1'b0; Mem_UB = 1'b0; Mem_LB = 1'b0;
        ADDR = 20'd12; Data_in = 16'hC0DE;
        tick();
        release_bus();
        tick();
        tick();
        checks++;
        if (conf1 !== want_c) begin
            errors++;
            $display("FAIL conflict_sticky: got %b want %b", conf1, want_c);
        end
        read1(20'd12, 1'b0, 1'b0, d, v);
        checks++;
        if (d !== 16'hC0DE) begin
            errors++;
            $display("FAIL conflict_commit: data=%h want c0de", d);
        end
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        tick();
        checks++;
        if (conf1 !== 1'b0) begin
            errors++;
            $display("FAIL conflict_clear: got %b want 0", conf1);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_lanes();
        test_single_commit();
        test_write_priority();
        test_latency3();
        test_reset_mid_op();
        test_conflict();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
